sepe_dup_stream: RTL and testbench

- Parametrised successor to the SEPE-QED fetch-side instruction FIFO pair.
- Accepts original instructions, each paired with its precomputed duplicate. Originals are pushed to an output queue; duplicates are buffered in a dup queue.
- A registered ORIG/DUP mode FSM decides when buffered duplicates replay into the output queue.
- Sits between the fetch mux and the decode-side consumer, which pulls instructions through out_rd.

---
 rtl/sepe_dup_stream.sv | 198 +++++++++++++++++++
 tb/tb_sepe_dup_stream.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sepe_dup_stream.sv
// ----------------------------------------------------------------------------
// sepe_dup_stream
//   Fetch-side original/duplicate instruction stream for SEPE-QED.
//   Originals go straight into the output queue while their precomputed
//   duplicates are buffered in a dup queue. A registered ORIG/DUP mode FSM
//   decides when buffered duplicates are replayed into the output queue.
//   The decode-side consumer pulls words through out_rd; the head is
//   first-word-fall-through and reads as NOP_INSN whenever no pull succeeds.
//
//   Optional feature (macro SEPE_DUP_AUTO_EN): dup occupancy at or above
//   AUTO_THRESH also forces ORIG->DUP, independent of exe_dup.
// ----------------------------------------------------------------------------
module sepe_dup_stream #(
  parameter int                INSN_W      = 32,
  parameter int                DUP_DEPTH   = 8,
  parameter int                OUT_DEPTH   = 16,
  parameter logic [INSN_W-1:0] NOP_INSN    = INSN_W'(32'h0000_0013),
  parameter int                AUTO_THRESH = 6,
  localparam int               DC_W        = $clog2(DUP_DEPTH + 1),
  localparam int               OC_W        = $clog2(OUT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [INSN_W-1:0] in_insn,
  input  logic [INSN_W-1:0] in_dup_insn,
  output logic              in_ready,
  input  logic              exe_dup,
  input  logic              out_rd,
  output logic [INSN_W-1:0] out_rdata,
  output logic              out_empty,
  output logic [DC_W-1:0]   dup_count,
  output logic [OC_W-1:0]   out_count,
  output logic              mode
);

  localparam int DP_W = $clog2(DUP_DEPTH);
  localparam int OP_W = $clog2(OUT_DEPTH);

  // Elaboration-time parameter legality checks.
  if ((DUP_DEPTH < 2) || ((DUP_DEPTH & (DUP_DEPTH - 1)) != 0)) begin : g_bad_dup_depth
    $error("DUP_DEPTH must be a power of two >= 2");
  end
  if ((OUT_DEPTH < 2) || ((OUT_DEPTH & (OUT_DEPTH - 1)) != 0)) begin : g_bad_out_depth
    $error("OUT_DEPTH must be a power of two >= 2");
  end
  if ((AUTO_THRESH < 1) || (AUTO_THRESH > DUP_DEPTH)) begin : g_bad_auto_thresh
    $error("AUTO_THRESH must lie in 1..DUP_DEPTH");
  end

  typedef enum logic {
    MODE_ORIG = 1'b0,
    MODE_DUP  = 1'b1
  } mode_e;

  // State
  mode_e             r_mode;
  logic [INSN_W-1:0] r_dup_mem [DUP_DEPTH];
  logic [INSN_W-1:0] r_out_mem [OUT_DEPTH];
  logic [DP_W-1:0]   r_dup_wr_ptr;
  logic [DP_W-1:0]   r_dup_rd_ptr;
  logic [OP_W-1:0]   r_out_wr_ptr;
  logic [OP_W-1:0]   r_out_rd_ptr;
  logic [DC_W-1:0]   r_dup_count;
  logic [OC_W-1:0]   r_out_count;

  // Combinational control
  mode_e             w_mode_next;
  logic              w_out_full;
  logic              w_dup_full;
  logic              w_out_empty;
  logic              w_dup_empty;
  logic              w_is_nop;
  logic              w_auto_trip;
  logic              w_orig_push;
  logic              w_replay;
  logic              w_out_push;
  logic              w_out_pop;
  logic [INSN_W-1:0] w_out_wdata;

  // Status comes only from registered counts: no same-cycle bypass.
  assign w_out_full  = (r_out_count == OC_W'(OUT_DEPTH));
  assign w_dup_full  = (r_dup_count == DC_W'(DUP_DEPTH));
  assign w_out_empty = (r_out_count == '0);
  assign w_dup_empty = (r_dup_count == '0);
  assign w_is_nop    = (in_insn == NOP_INSN);

`ifdef SEPE_DUP_AUTO_EN
  assign w_auto_trip = (r_dup_count >= DC_W'(AUTO_THRESH));
`else
  assign w_auto_trip = 1'b0;
`endif

  // Next mode plus per-cycle push/replay/accept decisions for the current mode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_mode_next = r_mode;
    w_orig_push = 1'b0;
    w_replay    = 1'b0;
    in_ready    = 1'b0;
    if (rstn) begin
      case (r_mode)
        MODE_ORIG: begin
          w_orig_push = in_valid & ~w_is_nop & ~w_out_full & ~w_dup_full;
          // NOPs are swallowed: accepted but never written.
          in_ready    = w_is_nop | w_orig_push;
          if (exe_dup || w_auto_trip) begin
            w_mode_next = MODE_DUP;
          end
        end
        MODE_DUP: begin
          w_replay = ~w_dup_empty & ~w_out_full;
          // Stay in DUP until every buffered duplicate has been replayed.
          if (!exe_dup && w_dup_empty) begin
            w_mode_next = MODE_ORIG;
          end
        end
        default: w_mode_next = MODE_ORIG;
      endcase
    end
  end

  // The output queue has a single writer per cycle: originals in ORIG mode,
  // replayed duplicates in DUP mode.
  assign w_out_push  = w_orig_push | w_replay;
  assign w_out_wdata = w_replay ? r_dup_mem[r_dup_rd_ptr] : in_insn;
  assign w_out_pop   = rstn & out_rd & ~w_out_empty;

  // Mode register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      r_mode <= MODE_ORIG;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  // Pointers and occupancy counts for both queues.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dup_wr_ptr <= '0;
      r_dup_rd_ptr <= '0;
      r_out_wr_ptr <= '0;
      r_out_rd_ptr <= '0;
      r_dup_count  <= '0;
      r_out_count  <= '0;
    end else begin
      if (w_orig_push) begin
        r_dup_wr_ptr <= r_dup_wr_ptr + DP_W'(1);
      end
      if (w_replay) begin
        r_dup_rd_ptr <= r_dup_rd_ptr + DP_W'(1);
      end
      if (w_out_push) begin
        r_out_wr_ptr <= r_out_wr_ptr + OP_W'(1);
      end
      if (w_out_pop) begin
        r_out_rd_ptr <= r_out_rd_ptr + OP_W'(1);
      end

      // Dup push and replay never coincide: they belong to different modes.
      if (w_orig_push) begin
        r_dup_count <= r_dup_count + DC_W'(1);
      end else if (w_replay) begin
        r_dup_count <= r_dup_count - DC_W'(1);
      end

      case ({w_out_push, w_out_pop})
        2'b10:   r_out_count <= r_out_count + OC_W'(1);
        2'b01:   r_out_count <= r_out_count - OC_W'(1);
        default: r_out_count <= r_out_count;
      endcase
    end
  end

  // Queue storage writes.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately not reset; the pointers and counts
    // define validity, and stale words are never observable.
    if (w_orig_push) begin
      r_dup_mem[r_dup_wr_ptr] <= in_dup_insn;
    end
    if (w_out_push) begin
      r_out_mem[r_out_wr_ptr] <= w_out_wdata;
    end
  end

  // Outputs
  assign out_rdata = w_out_pop ? r_out_mem[r_out_rd_ptr] : NOP_INSN;
  assign out_empty = ~rstn | w_out_empty;
  assign dup_count = r_dup_count;
  assign out_count = r_out_count;
  assign mode      = (r_mode == MODE_DUP);

endmodule

// File: tb/tb_sepe_dup_stream.sv
// ----------------------------------------------------------------------------
// tb_sepe_dup_stream
//   Directed bench for sepe_dup_stream with default parameters. A table of
//   per-cycle vectors covers reset, ORIG pushes, NOP drops and a short replay;
//   hand-written sequences cover full/stall, early exe_dup release, reset in
//   the middle of a replay, and the optional auto-threshold switch
//   (SEPE_DUP_AUTO_EN).
// ----------------------------------------------------------------------------
module tb_sepe_dup_stream;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_insn;
  logic [31:0] in_dup_insn;
  logic        in_ready;
  logic        exe_dup;
  logic        out_rd;
  logic [31:0] out_rdata;
  logic        out_empty;
  logic [3:0]  dup_count;
  logic [4:0]  out_count;
  logic        mode;

  sepe_dup_stream dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_insn     (in_insn),
    .in_dup_insn (in_dup_insn),
    .in_ready    (in_ready),
    .exe_dup     (exe_dup),
    .out_rd      (out_rd),
    .out_rdata   (out_rdata),
    .out_empty   (out_empty),
    .dup_count   (dup_count),
    .out_count   (out_count),
    .mode        (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        rstn;
    logic        vld;
    logic [31:0] insn;
    logic [31:0] dup;
    logic        exe;
    logic        rd;
    logic        rdy;
    logic [31:0] rdata;
    logic        empty;
    logic [3:0]  dcnt;
    logic [4:0]  ocnt;
    logic        mode;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                       input logic [31:0] d, input logic e, input logic rd);
    rstn        = r;
    in_valid    = v;
    in_insn     = ins;
    in_dup_insn = d;
    exe_dup     = e;
    out_rd      = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_pop();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Pull with exe_dup low until queue, dup buffer and mode are all idle,
  // checking order against the expected stream and that DUP is held while
  // duplicates remain.
  task automatic drain(input string name);
    int n;
    n = 0;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    while (n < 100) begin
      @(negedge clk);
      if (dup_count != 0) check({name, "_mode_held"}, {31'b0, mode}, 32'd1);
      if (!out_empty) begin
        check({name, "_rdata"}, out_rdata, exp_pop());
      end else if (dup_count == 0 && mode == 1'b0) begin
        break;
      end
      step();
      n++;
    end
    check({name, "_in_budget"}, {31'b0, n < 100}, 32'd1);
    check({name, "_all_emitted"}, exp_q.size(), 32'd0);
    check({name, "_out_count"}, {27'b0, out_count}, 32'd0);
    step();
  endtask

  function automatic vec_t mk(logic r, logic v, logic [31:0] ins, logic [31:0] d,
                              logic e, logic rd, logic rdy, logic [31:0] rdat,
                              logic emp, logic [3:0] dc, logic [4:0] oc, logic m);
    vec_t t;
    t.rstn = r;   t.vld = v;     t.insn = ins;  t.dup = d;
    t.exe = e;    t.rd = rd;     t.rdy = rdy;   t.rdata = rdat;
    t.empty = emp; t.dcnt = dc;  t.ocnt = oc;   t.mode = m;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //            rstn vld insn          dup           exe rd | rdy rdata         emp dcnt ocnt mode
    tbl[0]  = mk(1'b0, 1, 32'hA1,       32'hD1,       0,  1,   0,  NOP,          1,  0,   0,   0);
    tbl[1]  = mk(1'b1, 0, 32'h0,        32'h0,        0,  1,   0,  NOP,          1,  0,   0,   0);
    tbl[2]  = mk(1'b1, 1, 32'hA1,       32'hD1,       0,  0,   1,  NOP,          1,  0,   0,   0);
    tbl[3]  = mk(1'b1, 1, 32'hA2,       32'hD2,       0,  0,   1,  NOP,          0,  1,   1,   0);
    tbl[4]  = mk(1'b1, 1, NOP,          32'hEE,       0,  0,   1,  NOP,          0,  2,   2,   0);
    tbl[5]  = mk(1'b1, 1, 32'hA3,       32'hD3,       0,  0,   1,  NOP,          0,  2,   2,   0);
    tbl[6]  = mk(1'b1, 1, NOP,          32'hEE,       0,  0,   1,  NOP,          0,  3,   3,   0);
    tbl[7]  = mk(1'b1, 1, NOP,          32'hEE,       0,  0,   1,  NOP,          0,  3,   3,   0);
    tbl[8]  = mk(1'b1, 0, 32'hB0,       32'h0,        1,  1,   0,  32'hA1,       0,  3,   3,   0);
    tbl[9]  = mk(1'b1, 1, NOP,          32'hEE,       1,  1,   0,  32'hA2,       0,  3,   2,   1);
    tbl[10] = mk(1'b1, 0, 32'h0,        32'h0,        0,  1,   0,  32'hA3,       0,  2,   2,   1);
    tbl[11] = mk(1'b1, 0, 32'h0,        32'h0,        0,  1,   0,  32'hD1,       0,  1,   2,   1);
    tbl[12] = mk(1'b1, 0, 32'h0,        32'h0,        0,  1,   0,  32'hD2,       0,  0,   2,   1);
    tbl[13] = mk(1'b1, 0, 32'hB0,       32'h0,        0,  1,   0,  32'hD3,       0,  0,   1,   0);
    tbl[14] = mk(1'b1, 0, 32'h0,        32'h0,        0,  1,   0,  NOP,          1,  0,   0,   0);

    // First reset cycle: state is unknown until this edge.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rstn, tbl[i].vld, tbl[i].insn, tbl[i].dup, tbl[i].exe, tbl[i].rd);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, tbl[i].rdy});
      check($sformatf("vec%0d_out_rdata", i), out_rdata,          tbl[i].rdata);
      check($sformatf("vec%0d_out_empty", i), {31'b0, out_empty}, {31'b0, tbl[i].empty});
      check($sformatf("vec%0d_dup_count", i), {28'b0, dup_count}, {28'b0, tbl[i].dcnt});
      check($sformatf("vec%0d_out_count", i), {27'b0, out_count}, {27'b0, tbl[i].ocnt});
      check($sformatf("vec%0d_mode", i),      {31'b0, mode},      {31'b0, tbl[i].mode});
      step();
    end

    // ---------------- fill to dup_full, replay to out_full, stall ----------------
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 32'h100 + i, 32'h200 + i, 1'b0, 1'b0);
      @(negedge clk);
      check("fill_in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.push_back(32'h100 + i);
      step();
    end
    drive(1'b1, 1'b1, 32'h108, 32'h208, 1'b0, 1'b0);
    @(negedge clk);
    check("dup_full_in_ready", {31'b0, in_ready}, 32'd0);
    check("dup_full_dup_count", {28'b0, dup_count}, 32'd8);
    check("dup_full_out_count", {27'b0, out_count}, 32'd8);
    step();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h200 + i);

    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n = 0;
    while (n < 20 && out_count != 5'd16) begin
      step();
      n++;
    end
    check("replay_fill_in_budget", {31'b0, n < 20}, 32'd1);
    @(negedge clk);
    check("replay_fill_mode", {31'b0, mode}, 32'd1);
    check("replay_fill_dup_count", {28'b0, dup_count}, 32'd0);
    check("replay_fill_out_count", {27'b0, out_count}, 32'd16);
    step();

    // Release exe_dup: one DUP cycle, then ORIG with the output queue full.
    drive(1'b1, 1'b1, 32'h1FF, 32'h2FF, 1'b0, 1'b0);
    @(negedge clk);
    check("dup_mode_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    @(negedge clk);
    check("out_full_mode", {31'b0, mode}, 32'd0);
    check("out_full_in_ready", {31'b0, in_ready}, 32'd0);
    step();

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      if (i == 0) check("out_full_blocked_count", {27'b0, out_count}, 32'd16);
      check("partial_read_rdata", out_rdata, exp_pop());
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h110 + i, 32'h210 + i, 1'b0, 1'b0);
      @(negedge clk);
      check("refill_in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.push_back(32'h110 + i);
      step();
    end

    // DUP with a full output queue: replay must stall.
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_dup_count", {28'b0, dup_count}, 32'd4);
      check("stall_out_count", {27'b0, out_count}, 32'd16);
      check("stall_mode", {31'b0, mode}, 32'd1);
      step();
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h210 + i);

    // One pull frees a slot; replay refills it on the following edge.
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    check("pulse_rdata", out_rdata, exp_pop());
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("pulse_dup_count", {28'b0, dup_count}, 32'd4);
    check("pulse_out_count", {27'b0, out_count}, 32'd15);
    step();
    @(negedge clk);
    check("resume_dup_count", {28'b0, dup_count}, 32'd3);
    check("resume_out_count", {27'b0, out_count}, 32'd16);
    step();
    drain("drain_full");

    // ---------------- early exe_dup release with dup_count=5 ----------------
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 32'h300 + i, 32'h400 + i, 1'b0, 1'b0);
      @(negedge clk);
      check("early_fill_in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.push_back(32'h300 + i);
      step();
    end
    for (int i = 0; i < 7; i++) exp_q.push_back(32'h400 + i);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n = 0;
    while (n < 20 && dup_count != 4'd5) begin
      step();
      n++;
    end
    check("early_reach5_in_budget", {31'b0, n < 20}, 32'd1);
    drain("drain_early");

    // ---------------- reset in the middle of a replay ----------------
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'h600 + i, 32'h680 + i, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    step();
    step();
    drive(1'b0, 1'b1, 32'h6FF, 32'h7FF, 1'b1, 1'b1);
    @(negedge clk);
    check("mid_reset_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_reset_rdata", out_rdata, NOP);
    check("mid_reset_empty", {31'b0, out_empty}, 32'd1);
    step();
    exp_q.delete();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("post_reset_dup_count", {28'b0, dup_count}, 32'd0);
    check("post_reset_out_count", {27'b0, out_count}, 32'd0);
    check("post_reset_mode", {31'b0, mode}, 32'd0);
    check("post_reset_empty", {31'b0, out_empty}, 32'd1);
    check("post_reset_rdata", out_rdata, NOP);
    step();
    @(negedge clk);
    check("post_reset_idle_count", {27'b0, out_count}, 32'd0);
    step();

    // ---------------- dup occupancy threshold ----------------
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 32'h500 + i, 32'h580 + i, 1'b0, 1'b0);
      @(negedge clk);
      check("thresh_fill_in_ready", {31'b0, in_ready}, 32'd1);
      exp_q.push_back(32'h500 + i);
      step();
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h580 + i);
`ifdef SEPE_DUP_AUTO_EN
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h5FF, 32'h5FE, 1'b0, 1'b0);
    @(negedge clk);
    check("auto_mode", {31'b0, mode}, 32'd1);
    check("auto_in_ready", {31'b0, in_ready}, 32'd0);
    step();
`else
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    @(negedge clk);
    check("no_auto_mode", {31'b0, mode}, 32'd0);
    check("no_auto_dup_count", {28'b0, dup_count}, 32'd6);
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
`endif
    drain("drain_thresh");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
